divider_mem_ctrl: RTL

Sequencer for the 8-lane CDF divider memory datapath in the histogram-equalisation pipeline. It walks the scratch memory in batches of two 128-bit CDF lines. For each batch it reads both lines, tells the datapath when read data is valid, and starts the eight dividers. It then waits for all of them to finish and issues two scratch-memory writes, aligned to the cycles when the datapath presents each result line on `sc_mem_wt_data`.

---
 rtl/divider_mem_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/divider_mem_ctrl.sv
// Sequences read, divide and write-back of two CDF lines per batch for the 8-lane divider datapath.
// Latency: RD_LAT+12 cycles per batch plus divide time. No backpressure; stalls only on all_div_done.
// Optional divider watchdog is enabled by defining DIVCTRL_TIMEOUT_EN.
module divider_mem_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int NUM_LINES = 64,
    parameter int RD_BASE   = 0,
    parameter int WR_BASE   = 128,
    parameter int RD_LAT    = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              all_div_done,
    output logic              busy,
    output logic              done,
    output logic              sc_mem_rd_en,
    output logic [ADDR_W-1:0] sc_mem_rd_addr1,
    output logic [ADDR_W-1:0] sc_mem_rd_addr2,
    output logic              sc_mem_rd_data_rdy,
    output logic              div_start,
    output logic              sc_mem_wt_en,
    output logic [ADDR_W-1:0] sc_mem_wt_addr,
    output logic              timeout_err
);
    localparam int K_W = (NUM_LINES > 2) ? $clog2(NUM_LINES / 2) : 1;
    localparam logic [K_W-1:0] K_LAST   = K_W'(NUM_LINES / 2 - 1);
    localparam logic [2:0]     RD_LAT_M1 = 3'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_RDY, S_LATCH, S_START, S_MASK,
        S_DIV_WAIT, S_WR1_WAIT, S_WR1, S_GAP, S_WR2, S_NEXT
    } state_t;

    state_t         state;
    logic [K_W-1:0] k;
    logic [2:0]     cnt;

    // Line 2*kk+odd relative to base, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] line_addr(input int base, input logic [K_W-1:0] kk,
                                                    input logic odd);
        return ADDR_W'(base) + ADDR_W'({kk, odd});
    endfunction

`ifdef DIVCTRL_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wdog;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            k                  <= '0;
            cnt                <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            sc_mem_rd_en       <= 1'b0;
            sc_mem_rd_addr1    <= '0;
            sc_mem_rd_addr2    <= '0;
            sc_mem_rd_data_rdy <= 1'b0;
            div_start          <= 1'b0;
            sc_mem_wt_en       <= 1'b0;
            sc_mem_wt_addr     <= '0;
`ifdef DIVCTRL_TIMEOUT_EN
            wdog               <= '0;
            timeout_err        <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; each is raised on entry to its own state.
            done               <= 1'b0;
            sc_mem_rd_en       <= 1'b0;
            sc_mem_rd_data_rdy <= 1'b0;
            div_start          <= 1'b0;
            sc_mem_wt_en       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state           <= S_RD_REQ;
                        busy            <= 1'b1;
                        sc_mem_rd_en    <= 1'b1;
                        sc_mem_rd_addr1 <= line_addr(RD_BASE, k, 1'b0);
                        sc_mem_rd_addr2 <= line_addr(RD_BASE, k, 1'b1);
`ifdef DIVCTRL_TIMEOUT_EN
                        timeout_err     <= 1'b0;
`endif
                    end
                end
                S_RD_REQ: begin
                    state <= S_RD_WAIT;
                    cnt   <= RD_LAT_M1;
                end
                S_RD_WAIT: begin
                    if (cnt == 3'd0) begin
                        state              <= S_RDY;
                        sc_mem_rd_data_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RDY: begin
                    state <= S_LATCH;
                    cnt   <= 3'd1;
                end
                S_LATCH: begin
                    if (cnt == 3'd0) begin
                        state     <= S_START;
                        div_start <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_START: state <= S_MASK;
                S_MASK: begin
                    // Done flags left over from the previous batch are ignored until here.
                    state <= S_DIV_WAIT;
`ifdef DIVCTRL_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                S_DIV_WAIT: begin
                    if (all_div_done) begin
                        state <= S_WR1_WAIT;
`ifdef DIVCTRL_TIMEOUT_EN
                    end else if (wdog == TO_LAST) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        k           <= '0;
                    end else begin
                        wdog <= wdog + 8'd1;
`endif
                    end
                end
                S_WR1_WAIT: begin
                    state          <= S_WR1;
                    sc_mem_wt_en   <= 1'b1;
                    sc_mem_wt_addr <= line_addr(WR_BASE, k, 1'b0);
                end
                S_WR1: begin
                    state <= S_GAP;
                    cnt   <= 3'd1;
                end
                S_GAP: begin
                    if (cnt == 3'd0) begin
                        state          <= S_WR2;
                        sc_mem_wt_en   <= 1'b1;
                        sc_mem_wt_addr <= line_addr(WR_BASE, k, 1'b1);
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_WR2: state <= S_NEXT;
                S_NEXT: begin
                    if (k == K_LAST) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        k     <= '0;
                    end else begin
                        state           <= S_RD_REQ;
                        k               <= k + K_W'(1);
                        sc_mem_rd_en    <= 1'b1;
                        sc_mem_rd_addr1 <= line_addr(RD_BASE, k + K_W'(1), 1'b0);
                        sc_mem_rd_addr2 <= line_addr(RD_BASE, k + K_W'(1), 1'b1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
